// File: rtl/barrel_shifter.sv
// barrel_shifter: registered log2(N)-stage logical shifter; defining BARREL_SHIFTER_ROTATE_EN adds a rot input for circular rotate
module barrel_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               dir,
`ifdef BARREL_SHIFTER_ROTATE_EN
  input  logic               rot,
`endif
  output logic [WIDTH-1:0]   data_out,
  output logic               out_valid
);
  logic rot_on;
`ifdef BARREL_SHIFTER_ROTATE_EN
  assign rot_on = rot;
`else
  assign rot_on = 1'b0;
`endif
  logic [WIDTH-1:0] fwd, res;
  logic [WIDTH-1:0] stage [SHIFT_W+1];
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign fwd[i] = dir ? data_in[WIDTH-1-i] : data_in[i];
    assign res[i] = dir ? stage[SHIFT_W][WIDTH-1-i] : stage[SHIFT_W][i];
  end
  assign stage[0] = fwd;
  for (genvar s = 0; s < SHIFT_W; s++) begin : g_stage
    localparam int D = 2 ** s;
    assign stage[s+1] = shift[s] ? {stage[s][WIDTH-D-1:0], rot_on ? stage[s][WIDTH-1:WIDTH-D] : D'(0)} : stage[s];
  end
  // output register: capture on accepted input, hold data otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) data_out <= res;
    end
  end
endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter: randomized and directed scoreboard bench against a behavioural shift/rotate model
module tb_barrel_shifter;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic [7:0] data_in = 0;
  logic [2:0] shift = 0;
  logic       dir = 0;
  logic       rot = 0;
  logic [7:0] data_out;
  logic       out_valid;
`ifdef BARREL_SHIFTER_ROTATE_EN
  localparam int RMAX = 1;
`else
  localparam int RMAX = 0;
`endif

  barrel_shifter #(.WIDTH(8), .SHIFT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .shift(shift), .dir(dir),
`ifdef BARREL_SHIFTER_ROTATE_EN
    .rot(rot),
`endif
    .data_out(data_out), .out_valid(out_valid));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; int c; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model(input int d, input int s, input int dr, input int r);
    int v;
    if (r != 0) v = dr ? ((d >> s) | (d << (8 - s))) : ((d << s) | (d >> (8 - s)));
    else v = dr ? (d >> s) : (d << s);
    return 8'(v & 'hFF);
  endfunction

  // monitor: pop expected result whenever the DUT presents one, else check hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", cyc - e.c, 1);
          chk("data_out", data_out, e.d);
          last = e.d;
        end
      end else chk("hold_data", data_out, last);
    end
  end

  task automatic issue(input logic v, input logic [7:0] d, input logic [2:0] s,
                       input logic dr, input logic r, input logic [7:0] e);
    exp_t x;
    @(negedge clk);
    in_valid = v; data_in = d; shift = s; dir = dr; rot = r;
    if (v) begin
      x.d = e; x.c = cyc;
      q.push_back(x);
    end
  endtask

  task automatic rnd(input logic v);
    logic [7:0] d; logic [2:0] s; logic dr, r;
    d = 8'($urandom); s = 3'($urandom); dr = 1'($urandom);
    r = (RMAX != 0) ? 1'($urandom) : 1'b0;
    issue(v, d, s, dr, r, model(d, s, dr, r));
  endtask

  initial begin
    // reset held with valid input applied
    in_valid = 1; data_in = 8'hFF; shift = 3'd1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_data", data_out, 0);
      chk("reset_valid", out_valid, 0);
    end
    in_valid = 0;
    rst_n = 1;
    // directed cases, back-to-back
    issue(1, 8'b10110110, 3'd2, 0, 0, 8'b11011000);
    issue(1, 8'b10111011, 3'd3, 1, 0, 8'b00010111);
    issue(1, 8'h81, 3'd0, 0, 0, 8'h81);
    issue(1, 8'h81, 3'd0, 1, 0, 8'h81);
    issue(1, 8'h81, 3'd7, 0, 0, 8'h80);
    issue(1, 8'h81, 3'd7, 1, 0, 8'h01);
    // valid gating with changing data
    repeat (4) rnd(0);
    if (RMAX != 0) begin
      issue(1, 8'b10110110, 3'd2, 0, 1, 8'b11011010);
      issue(1, 8'b10111011, 3'd3, 1, 1, 8'b01110111);
    end
    // exhaustive sweep
    for (int r = 0; r <= RMAX; r++)
      for (int dr = 0; dr < 2; dr++)
        for (int s = 0; s < 8; s++)
          for (int d = 0; d < 256; d++)
            issue(1, 8'(d), 3'(s), 1'(dr), 1'(r), model(d, s, dr, r));
    // random traffic with random valid gaps
    repeat (2000) rnd(1'($urandom_range(0, 3) != 0));
    // asynchronous reset mid-cycle discards in-flight state
    issue(1, 8'h81, 3'd0, 0, 0, 8'h81);
    @(posedge clk);
    #2;
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 0; in_valid = 0;
    #1;
    chk("async_reset_data", data_out, 0);
    chk("async_reset_valid", out_valid, 0);
    q.delete();
    last = 0;
    @(negedge clk);
    rst_n = 1;
    issue(1, 8'h3C, 3'd1, 1, 0, 8'h1E);
    issue(0, 8'h00, 3'd0, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- Registered logical barrel shifter.
- Shifts an N-bit word left or right by 0..N-1 positions in one clock.
- Used as a normalisation/alignment stage in the multiplier datapath.
- Built as log2(N) mux stages (shift by 1, 2, 4, …), followed by an output register with a valid flag.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two and at least 2.
- SHIFT_W, 3, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies data_in, shift and dir this cycle.
- data_in  input  WIDTH  operand word.
- shift  input  SHIFT_W  shift amount, unsigned, 0..WIDTH-1.
- dir  input  1  direction: 0 = left (toward MSB), 1 = right (toward LSB).
- data_out  output  WIDTH  shifted result, registered.
- out_valid  output  1  data_out holds the result of an accepted input.

Behaviour:
- Reset: rst_n low immediately (asynchronously) forces data_out = 0 and out_valid = 0.
  - Reset mid-operation discards the in-flight result.
  - Release is synchronous to the next clk edge after rst_n goes high.
- Latency: exactly 1 cycle.
  - Inputs sampled at rising edge T with in_valid = 1 produce data_out and out_valid = 1 after edge T.
- in_valid = 0 at an edge:
  - out_valid goes to 0.
  - data_out holds its previous value and does not toggle.
- No backpressure: a new operand is accepted every cycle.
- Left shift: data_out = (data_in << shift) truncated to WIDTH bits; vacated LSBs are filled with 0.
- Right shift: data_out = data_in >> shift, logical; vacated MSBs are filled with 0, with no sign extension.
- shift = 0: data_out = data_in for either direction.
- shift = WIDTH-1: only one bit survives (LSB moved to MSB for left, MSB moved to LSB for right).
- Structure:
  - Stage k shifts by 2^k when shift[k] = 1, for k = 0..SHIFT_W-1.
  - Direction is handled by bit-reversing the input and output around a left-shift core, or by an equivalent two-direction mux network.
  - The result must not depend on which form is used.
- All shift-amount values are legal; there are no out-of-range codes.

Optional Feature:
- Macro: BARREL_SHIFTER_ROTATE_EN.
- Defined:
  - Adds input port rot (1 bit), sampled together with data_in.
  - rot = 1: bits shifted out re-enter at the opposite end (circular rotate) in the direction given by dir.
  - rot = 0: behaviour identical to the logical shift above.
  - Latency and reset behaviour are unchanged.
- Undefined:
  - No rot port.
  - Logical shift only.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1 and data_in = 8'hFF -> data_out = 8'h00 and out_valid = 0 throughout. Assert rst_n = 0 asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
- Left shift: data_in = 8'b10110110, dir = 0, shift = 2, in_valid = 1 -> one cycle later data_out = 8'b11011000, out_valid = 1.
- Right shift: data_in = 8'b10111011, dir = 1, shift = 3 -> data_out = 8'b00010111 one cycle later. Back-to-back with the previous scenario -> consecutive results on consecutive cycles.
- Boundaries:
  - data_in = 8'h81, shift = 0, either dir -> 8'h81.
  - data_in = 8'h81, shift = 7, dir = 0 -> 8'h80.
  - data_in = 8'h81, shift = 7, dir = 1 -> 8'h01.
- Valid gating: in_valid = 0 with changing data_in -> out_valid = 0 and data_out unchanged from the last accepted result.
- BARREL_SHIFTER_ROTATE_EN with rot = 1:
  - 8'b10110110, dir = 0, shift = 2 -> 8'b11011010.
  - 8'b10111011, dir = 1, shift = 3 -> 8'b01110111.
  - Exhaustive sweep of all data_in, shift and dir values against a reference model, with rot = 0 and rot = 1.
